// File: rtl/llpm_arb_pkg.sv
// Shared arbitration helpers: rotated find-first used by round-robin arbiters.
// Sized for up to MaxInputs requesters; callers zero-extend their vectors.
package llpm_arb_pkg;

    localparam int unsigned MaxInputs   = 32;
    localparam int unsigned MaxIdxWidth = 5;

    typedef struct packed {
        logic                   any;
        logic [MaxIdxWidth-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[0..n-1] scanning upward from ptr with wrap; idx = ptr when none set.
    function automatic rr_pick_t rr_first(
        input logic [MaxInputs-1:0]   valid,
        input logic [MaxIdxWidth-1:0] ptr,
        input int unsigned            n
    );
        rr_pick_t             r;
        logic [MaxIdxWidth:0] pos;
        r.any = 1'b0;
        r.idx = ptr;
        for (int unsigned k = 0; k < MaxInputs; k++) begin
            pos = {1'b0, ptr} + (MaxIdxWidth+1)'(k);
            if (pos >= (MaxIdxWidth+1)'(n)) begin
                pos = pos - (MaxIdxWidth+1)'(n);
            end
            if (!r.any && (k < n) && valid[pos[MaxIdxWidth-1:0]]) begin
                r.any = 1'b1;
                r.idx = pos[MaxIdxWidth-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i.
// Latency: zero cycles. Backpressure: none, pure function of its inputs.
// Backpressure is applied by the instantiating arbiter.
module rr_pick
    import llpm_arb_pkg::*;
#(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned IdxWidth  = 2
) (
    input  logic [NumInputs-1:0] valid_i,
    input  logic [IdxWidth-1:0]  ptr_i,
    output logic [IdxWidth-1:0]  idx_o,
    output logic                 any_o
);

    rr_pick_t res;

    always_comb begin
        res   = rr_first(MaxInputs'(valid_i), MaxIdxWidth'(ptr_i), NumInputs);
        idx_o = IdxWidth'(res.idx);
        any_o = res.any;
    end

endmodule

// File: rtl/rr_merge.sv
// Round-robin merge of NumInputs valid/bp producers onto one downstream channel.
// Latency: zero cycles (din->dout and dout_bp->din_bp are combinational).
// Backpressure: a stalled grant is locked until accepted; non-granted inputs see din_bp=1.
module rr_merge
    import llpm_arb_pkg::*;
#(
    parameter int unsigned Width     = 8,
    parameter int unsigned NumInputs = 4,
    localparam int unsigned IdxWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NumInputs*Width-1:0]     din,
    input  logic [NumInputs-1:0]           din_valid,
    output logic [NumInputs-1:0]           din_bp,
    output logic [Width-1:0]               dout,
    output logic [IdxWidth-1:0]            dout_idx,
    output logic                           dout_valid,
    input  logic                           dout_bp
);

    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic                locked_q, locked_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

    logic [IdxWidth-1:0] pick_idx;
    logic                pick_any;
    logic [IdxWidth-1:0] grant;
    logic [Width-1:0]    din_arr [NumInputs];

    for (genvar i = 0; i < NumInputs; i++) begin : g_unpack
        assign din_arr[i] = din[i*Width +: Width];
    end

    rr_pick #(
        .NumInputs (NumInputs),
        .IdxWidth  (IdxWidth)
    ) u_pick (
        .valid_i (din_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // While locked, only the locked input's valid reaches dout_valid.
    always_comb begin
        grant      = locked_q ? lock_idx_q : pick_idx;
        dout_valid = locked_q ? din_valid[lock_idx_q] : pick_any;
        dout       = din_arr[grant];
        dout_idx   = grant;
        for (int i = 0; i < NumInputs; i++) begin
            din_bp[i] = !(dout_valid && !dout_bp && (grant == IdxWidth'(i)));
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (dout_valid && !dout_bp) begin
            ptr_d    = (grant == IdxWidth'(NumInputs - 1)) ? '0 : grant + 1'b1;
            locked_d = 1'b0;
        end else if (dout_valid && dout_bp && !locked_q) begin
            locked_d   = 1'b1;
            lock_idx_d = grant;
        end else if (locked_q && !dout_valid) begin
            // Locked producer withdrew its token; fall back to normal arbitration.
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_rr_merge.sv
// Bench for rr_merge: directed scenarios then random traffic against a behavioural model.
// A second 3-input instance checks non-power-of-two rotation.
module tb_rr_merge;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic [N*W-1:0]   din;
    logic [N-1:0]     din_valid;
    logic [N-1:0]     din_bp;
    logic [W-1:0]     dout;
    logic [IW-1:0]    dout_idx;
    logic             dout_valid;
    logic             dout_bp;

    logic             resetn3;
    logic [3*W-1:0]   din3;
    logic [2:0]       din3_valid;
    logic [2:0]       din3_bp;
    logic [W-1:0]     dout3;
    logic [1:0]       dout3_idx;
    logic             dout3_valid;
    logic             dout3_bp;

    int n_vec = 0;
    int n_err = 0;

    // Model state: next-priority input, and the input whose stalled token is being held.
    int m_ptr  = 0;
    bit m_held = 1'b0;
    int m_hold = 0;
    int m3_cnt = 0;
    bit rst3_done = 1'b0;

    rr_merge #(.Width(W), .NumInputs(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .din_bp     (din_bp),
        .dout       (dout),
        .dout_idx   (dout_idx),
        .dout_valid (dout_valid),
        .dout_bp    (dout_bp)
    );

    rr_merge #(.Width(W), .NumInputs(3)) dut3 (
        .clk        (clk),
        .resetn     (resetn3),
        .din        (din3),
        .din_valid  (din3_valid),
        .din_bp     (din3_bp),
        .dout       (dout3),
        .dout_idx   (dout3_idx),
        .dout_valid (dout3_valid),
        .dout_bp    (dout3_bp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, output bit any);
        if (m_held) begin
            any = v[m_hold];
            return m_hold;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (v[c]) begin
                any = 1'b1;
                return c;
            end
        end
        any = 1'b0;
        return m_ptr;
    endfunction

    task automatic apply(input logic rst_n, input logic [N-1:0] v, input logic bp,
                         input logic [N*W-1:0] data, input bit chk, input string tag);
        int         g;
        bit         any;
        logic [N-1:0] exp_bp;
        logic [2:0]   exp_bp3;
        logic [W-1:0] exp_dout;
        @(negedge clk);
        resetn    = rst_n;
        din_valid = v;
        dout_bp   = bp;
        din       = data;
        if (!rst3_done) resetn3 = rst_n;
        #1;
        g        = model_grant(v, any);
        exp_bp   = '1;
        if (any && !bp) exp_bp[g] = 1'b0;
        exp_dout = data[g*W +: W];
        if (chk) begin
            check({tag, "/valid"}, 32'(dout_valid), 32'(any));
            check({tag, "/idx"},   32'(dout_idx),   32'(g));
            check({tag, "/dout"},  32'(dout),       32'(exp_dout));
            check({tag, "/din_bp"}, 32'(din_bp),    32'(exp_bp));
        end
        if (resetn3) begin
            exp_bp3 = 3'b111;
            exp_bp3[m3_cnt % 3] = 1'b0;
            check({tag, "/n3_idx"},   32'(dout3_idx),   32'(m3_cnt % 3));
            check({tag, "/n3_valid"}, 32'(dout3_valid), 32'd1);
            check({tag, "/n3_dout"},  32'(dout3),       32'(din3[(m3_cnt % 3)*W +: W]));
            check({tag, "/n3_bp"},    32'(din3_bp),     32'(exp_bp3));
            m3_cnt++;
        end
        if (rst_n) rst3_done = 1'b1;
        // Advance the model as the clock edge will.
        if (!rst_n) begin
            m_ptr  = 0;
            m_held = 1'b0;
            m_hold = 0;
        end else if (any && !bp) begin
            m_ptr  = (g + 1) % N;
            m_held = 1'b0;
        end else if (any && bp) begin
            m_held = 1'b1;
            m_hold = g;
        end else begin
            m_held = 1'b0;
        end
    endtask

    initial begin
        logic [N*W-1:0] fixed;
        fixed      = 32'h44332211;
        resetn     = 1'b0;
        resetn3    = 1'b0;
        din        = '0;
        din_valid  = '0;
        dout_bp    = 1'b0;
        din3       = 24'hCCBBAA;
        din3_valid = 3'b111;
        dout3_bp   = 1'b0;

        apply(1'b0, 4'b0000, 1'b0, fixed, 1'b0, "reset0");
        apply(1'b0, 4'b0000, 1'b0, fixed, 1'b1, "reset1");
        apply(1'b1, 4'b0000, 1'b0, fixed, 1'b1, "idle");

        for (int i = 0; i < 8; i++) apply(1'b1, 4'b1111, 1'b0, $urandom, 1'b1, "rotate");

        apply(1'b1, 4'b0010, 1'b1, fixed, 1'b1, "stall_first");
        for (int i = 0; i < 3; i++) apply(1'b1, 4'b0011, 1'b1, fixed, 1'b1, "stall_hold");
        apply(1'b1, 4'b0011, 1'b0, fixed, 1'b1, "stall_release");
        apply(1'b1, 4'b0001, 1'b0, fixed, 1'b1, "stall_wrap");

        apply(1'b1, 4'b0100, 1'b1, fixed, 1'b1, "rstlock_lock");
        apply(1'b1, 4'b0111, 1'b1, fixed, 1'b1, "rstlock_hold");
        apply(1'b0, 4'b0111, 1'b1, fixed, 1'b1, "rstlock_reset");
        apply(1'b1, 4'b0111, 1'b0, fixed, 1'b1, "rstlock_after");

        apply(1'b1, 4'b1000, 1'b1, fixed, 1'b1, "drop_lock");
        apply(1'b1, 4'b1010, 1'b1, fixed, 1'b1, "drop_hold");
        apply(1'b1, 4'b0010, 1'b1, fixed, 1'b1, "drop_cycle");
        apply(1'b1, 4'b0010, 1'b0, fixed, 1'b1, "drop_after");

        for (int i = 0; i < 1500; i++) begin
            logic rr;
            rr = ($urandom_range(63) != 0);
            apply(rr, 4'($urandom), 1'($urandom_range(2) == 0), $urandom, 1'b1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
